sync_pulse_multi: RTL and testbench



---
 rtl/sync_pulse_multi.sv | 151 +++++++++++++++
 tb/tb_sync_pulse_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_multi.sv
`default_nettype none
// ============================================================================
// Module      : sync_pulse_multi
// Description : Multi-channel asynchronous-level-to-pulse synchroniser.
//               Each channel passes its async level through a SYNC_STG-deep
//               flop chain and detects rising, falling or both edges
//               (selected at run time). Every detected event is reported as:
//               a one-cycle pulse, a sticky pending flag cleared by ack,
//               a saturating event count, and a sticky overflow flag set
//               when an event arrives while the previous one is still
//               pending and unacknowledged.
//
// Ports       : clk       - single clock, all logic on posedge
//               rst       - synchronous reset, active-high
//               async_in  - [CH] asynchronous level inputs
//               edge_mode - [2*CH] per-channel mode: 00 off, 01 rise,
//                           10 fall, 11 both
//               ack       - [CH] clears pending (event wins if simultaneous)
//               cnt_clr   - [CH] clears evt_cnt and overflow
//               pulse_out - [CH] one-cycle event pulse
//               pending   - [CH] sticky event flag, held until ack
//               overflow  - [CH] sticky event-while-pending flag
//               evt_cnt   - [CH*CNT_W] saturating per-channel counts
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_pulse_multi #(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       async_in,
  input  logic [2*CH-1:0]     edge_mode,
  input  logic [CH-1:0]       ack,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       pending,
  output logic [CH-1:0]       overflow,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  // Warm-up counter must hold SYNC_STG+1.
  localparam int                unsigned c_WU_W    = $clog2(SYNC_STG + 2);
  localparam logic [c_WU_W-1:0] c_WU_INIT = c_WU_W'(SYNC_STG + 1);
  localparam logic [c_WU_W-1:0] c_WU_ONE  = c_WU_W'(1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Shared warm-up counter. Reset clears the synchroniser to 0, so an input
  // already high through reset would look like a rising edge once it reaches
  // the chain output. Events are masked until that artefact has drained.
  // --------------------------------------------------------------------------
  logic [c_WU_W-1:0] warm_q;
  logic [c_WU_W-1:0] warm_d;
  logic              warm_busy;

  always_comb begin
    warm_d    = warm_q;
    warm_busy = (warm_q != '0);
    if (warm_busy) begin
      warm_d = warm_q - c_WU_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q <= c_WU_INIT;
    end else begin
      warm_q <= warm_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel datapath; channels share nothing but the warm-up mask.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;
    logic                pulse_q;
    logic                pend_q;
    logic                pend_d;
    logic                ovf_q;
    logic                ovf_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                s;
    logic                rise;
    logic                fall;
    logic                evt;

    assign s    = sync_q[SYNC_STG-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
      evt    = ((edge_mode[2*i] & rise) | (edge_mode[2*i+1] & fall)) & ~warm_busy;

      // Event has priority over ack so a fresh event is never lost.
      pend_d = pend_q;
      if (evt) begin
        pend_d = 1'b1;
      end else if (ack[i]) begin
        pend_d = 1'b0;
      end

      // Set dominates clear: an overflow coinciding with cnt_clr is kept.
      ovf_d = ovf_q;
      if (evt && pend_q && !ack[i]) begin
        ovf_d = 1'b1;
      end else if (cnt_clr[i]) begin
        ovf_d = 1'b0;
      end

      // A clear coinciding with an event counts that event.
      cnt_d = cnt_q;
      if (cnt_clr[i]) begin
        cnt_d = evt ? c_CNT_ONE : '0;
      end else if (evt && (cnt_q != c_CNT_MAX)) begin
        cnt_d = cnt_q + c_CNT_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= '0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
        pend_q  <= 1'b0;
        ovf_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STG-2:0], async_in[i]};
        prev_q  <= s;
        pulse_q <= evt;
        pend_q  <= pend_d;
        ovf_q   <= ovf_d;
        cnt_q   <= cnt_d;
      end
    end

    assign pulse_out[i]              = pulse_q;
    assign pending[i]                = pend_q;
    assign overflow[i]               = ovf_q;
    assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end : g_ch

endmodule : sync_pulse_multi
`default_nettype wire

// File: tb/tb_sync_pulse_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_pulse_multi
// Description : Self-checking bench for sync_pulse_multi (CH=4, SYNC_STG=2,
//               CNT_W=2). Table-driven vectors for latency, modes and the
//               ack handshake; hand-written sequences for warm-up,
//               simultaneous ack/clear, saturation and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_pulse_multi;

  localparam int CH       = 4;
  localparam int SYNC_STG = 2;
  localparam int CNT_W    = 2;

  logic                clk;
  logic                rst;
  logic [CH-1:0]       async_in;
  logic [2*CH-1:0]     edge_mode;
  logic [CH-1:0]       ack;
  logic [CH-1:0]       cnt_clr;
  logic [CH-1:0]       pulse_out;
  logic [CH-1:0]       pending;
  logic [CH-1:0]       overflow;
  logic [CH*CNT_W-1:0] evt_cnt;

  int errors = 0;
  int checks = 0;

  sync_pulse_multi #(
    .CH       (CH),
    .SYNC_STG (SYNC_STG),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .edge_mode (edge_mode),
    .ack       (ack),
    .cnt_clr   (cnt_clr),
    .pulse_out (pulse_out),
    .pending   (pending),
    .overflow  (overflow),
    .evt_cnt   (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;     // async_in
    logic [7:0] m;     // edge_mode
    logic [3:0] k;     // ack
    logic [3:0] c;     // cnt_clr
    int         n;     // clock edges to apply
    logic [3:0] p;     // expected pulse_out
    logic [3:0] pd;    // expected pending
    logic [3:0] ov;    // expected overflow
    logic [7:0] cnt;   // expected evt_cnt
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // ch0 rise, ch1 fall, ch2 both, ch3 off -> 8'h39
    tbl[0]  = '{4'hF, 8'h39, 4'h0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 8'h00};
    tbl[1]  = '{4'hF, 8'h39, 4'h0, 4'h0, 1, 4'h5, 4'h5, 4'h0, 8'h11};
    tbl[2]  = '{4'hF, 8'h39, 4'h0, 4'h0, 1, 4'h0, 4'h5, 4'h0, 8'h11};
    tbl[3]  = '{4'hF, 8'h39, 4'h0, 4'h0, 7, 4'h0, 4'h5, 4'h0, 8'h11};
    tbl[4]  = '{4'h0, 8'h39, 4'h0, 4'h0, 2, 4'h0, 4'h5, 4'h0, 8'h11};
    tbl[5]  = '{4'h0, 8'h39, 4'h0, 4'h0, 1, 4'h6, 4'h7, 4'h4, 8'h25};
    tbl[6]  = '{4'h0, 8'h39, 4'h0, 4'h0, 1, 4'h0, 4'h7, 4'h4, 8'h25};
    tbl[7]  = '{4'h0, 8'h39, 4'hF, 4'hF, 1, 4'h0, 4'h0, 4'h0, 8'h00};
    // handshake on ch0
    tbl[8]  = '{4'h1, 8'h39, 4'h0, 4'h0, 3, 4'h1, 4'h1, 4'h0, 8'h01};
    tbl[9]  = '{4'h1, 8'h39, 4'h0, 4'h0, 2, 4'h0, 4'h1, 4'h0, 8'h01};
    tbl[10] = '{4'h1, 8'h39, 4'h1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 8'h01};
    tbl[11] = '{4'h0, 8'h39, 4'h0, 4'h0, 3, 4'h0, 4'h0, 4'h0, 8'h01};
    tbl[12] = '{4'h1, 8'h39, 4'h0, 4'h0, 3, 4'h1, 4'h1, 4'h0, 8'h02};
    tbl[13] = '{4'h0, 8'h39, 4'h0, 4'h0, 3, 4'h0, 4'h1, 4'h0, 8'h02};
    tbl[14] = '{4'h1, 8'h39, 4'h0, 4'h0, 3, 4'h1, 4'h1, 4'h1, 8'h03};
    tbl[15] = '{4'h1, 8'h39, 4'h0, 4'h0, 1, 4'h0, 4'h1, 4'h1, 8'h03};
    tbl[16] = '{4'h1, 8'h39, 4'hF, 4'hF, 1, 4'h0, 4'h0, 4'h0, 8'h00};

    // ---------------- reset and warm-up ----------------
    rst       = 1'b1;
    async_in  = 4'hF;
    edge_mode = 8'hFF;
    ack       = 4'h0;
    cnt_clr   = 4'h0;
    repeat (3) tick();
    chk("reset pulse",    32'(pulse_out), 32'h0);
    chk("reset pending",  32'(pending),   32'h0);
    chk("reset overflow", 32'(overflow),  32'h0);
    chk("reset cnt",      32'(evt_cnt),   32'h0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("warmup%0d pulse", c),   32'(pulse_out), 32'h0);
      chk($sformatf("warmup%0d pending", c), 32'(pending),   32'h0);
      chk($sformatf("warmup%0d cnt", c),     32'(evt_cnt),   32'h0);
    end

    // bring inputs low with detection off so nothing is recorded
    edge_mode = 8'h00;
    async_in  = 4'h0;
    repeat (5) tick();
    chk("mode off pending", 32'(pending), 32'h0);
    chk("mode off cnt",     32'(evt_cnt), 32'h0);

    // ---------------- table-driven vectors ----------------
    for (int r = 0; r < 17; r++) begin
      async_in  = tbl[r].a;
      edge_mode = tbl[r].m;
      ack       = tbl[r].k;
      cnt_clr   = tbl[r].c;
      repeat (tbl[r].n) tick();
      chk($sformatf("row%0d pulse", r),    32'(pulse_out), 32'(tbl[r].p));
      chk($sformatf("row%0d pending", r),  32'(pending),   32'(tbl[r].pd));
      chk($sformatf("row%0d overflow", r), 32'(overflow),  32'(tbl[r].ov));
      chk($sformatf("row%0d cnt", r),      32'(evt_cnt),   32'(tbl[r].cnt));
    end
    ack     = 4'h0;
    cnt_clr = 4'h0;

    // ---------------- simultaneous ack / cnt_clr on ch1 (fall mode) ----------------
    async_in = 4'h3;
    repeat (4) tick();
    chk("sim ch1 rise ignored", 32'(pending[1]), 32'h0);
    async_in = 4'h1;
    repeat (3) tick();
    chk("sim fall1 pulse",   32'(pulse_out[1]), 32'h1);
    chk("sim fall1 pending", 32'(pending[1]),   32'h1);
    chk("sim fall1 cnt",     32'(evt_cnt[3:2]), 32'h1);
    async_in = 4'h3;
    repeat (4) tick();
    async_in = 4'h1;
    repeat (2) tick();
    ack = 4'h2;             // coincides with evt[1]
    tick();
    ack = 4'h0;
    chk("sim ack pulse",    32'(pulse_out[1]), 32'h1);
    chk("sim ack pending",  32'(pending[1]),   32'h1);
    chk("sim ack overflow", 32'(overflow[1]),  32'h0);
    chk("sim ack cnt",      32'(evt_cnt[3:2]), 32'h2);
    async_in = 4'h3;
    repeat (4) tick();
    async_in = 4'h1;
    repeat (2) tick();
    cnt_clr = 4'h2;         // coincides with evt[1]
    tick();
    cnt_clr = 4'h0;
    chk("sim clr cnt",      32'(evt_cnt[3:2]), 32'h1);
    chk("sim clr overflow", 32'(overflow[1]),  32'h1);
    chk("sim clr pending",  32'(pending[1]),   32'h1);

    // ---------------- saturation on ch2 (rise mode) ----------------
    edge_mode = 8'h19;
    for (int k = 0; k < 5; k++) begin
      async_in = 4'h5;
      repeat (3) tick();
      chk($sformatf("sat rise%0d cnt", k), 32'(evt_cnt[5:4]), (k < 2) ? 32'(k + 1) : 32'h3);
      async_in = 4'h1;
      repeat (3) tick();
    end
    chk("sat overflow set", 32'(overflow[2]), 32'h1);
    cnt_clr = 4'h4;
    tick();
    cnt_clr = 4'h0;
    chk("sat clr cnt",      32'(evt_cnt[5:4]), 32'h0);
    chk("sat clr overflow", 32'(overflow[2]),  32'h0);

    // ---------------- mid-operation reset ----------------
    async_in = 4'h0;
    repeat (4) tick();
    async_in = 4'h1;
    tick();                 // edge now in sync[0] of ch0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst pulse",    32'(pulse_out), 32'h0);
    chk("midrst pending",  32'(pending),   32'h0);
    chk("midrst overflow", 32'(overflow),  32'h0);
    chk("midrst cnt",      32'(evt_cnt),   32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("midrst%0d pulse", c),   32'(pulse_out), 32'h0);
      chk($sformatf("midrst%0d pending", c), 32'(pending),   32'h0);
      chk($sformatf("midrst%0d cnt", c),     32'(evt_cnt),   32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_pulse_multi
`default_nettype wire
